// File: rtl/utils_pkg.sv
// Shared core-bus types plus the arbiter's master id, write FSM states and grant helper.
package utils_pkg;

  localparam int CB_ARB_NUM_MASTERS = 2;

  typedef logic [1:0] cb_error_t;
  typedef logic       cb_master_id_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA
  } wr_arb_st_t;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic        rd_addr_valid;
    logic        rd_data_ready;
    logic [31:0] wr_addr;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    cb_error_t   rd_data_error;
    logic        rd_data_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    cb_error_t   wr_resp_error;
    logic        wr_resp_valid;
  } s_cb_miso_t;

  // Contention goes to the pointer in round-robin mode, otherwise to M1 (LSU).
  function automatic cb_master_id_t cb_arb_pick(input logic req0, input logic req1,
                                                input logic rr, input cb_master_id_t ptr);
    if (req0 && req1) return rr ? ptr : 1'b1;
    else if (req1)    return 1'b1;
    else              return 1'b0;
  endfunction

endpackage

// File: rtl/cb_arb_ord_fifo.sv
// Order FIFO of master ids; a push while full is accepted when a pop happens in the same cycle.
module cb_arb_ord_fifo
  import utils_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cb_master_id_t push_id,
  input  logic          pop,
  output cb_master_id_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr;
  cb_master_id_t mem [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/cb_arbiter.sv
// Two-master core-bus arbiter (M0 fetch, M1 LSU) onto one slave port with in-order response routing.
// Define NOX_CB_ARB_PERF_EN to get per-master granted-read counters on perf_rd_cnt_o.
module cb_arbiter
  import utils_pkg::*;
#(
  parameter int MAX_OT_TXN = 4,
  parameter int RR_EN      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  s_cb_mosi_t       m0_cb_mosi_i,
  output s_cb_miso_t       m0_cb_miso_o,
  input  s_cb_mosi_t       m1_cb_mosi_i,
  output s_cb_miso_t       m1_cb_miso_o,
  output s_cb_mosi_t       s_cb_mosi_o,
  input  s_cb_miso_t       s_cb_miso_i,
  output logic [1:0][31:0] perf_rd_cnt_o
);

  s_cb_mosi_t    m_mosi [CB_ARB_NUM_MASTERS];
  s_cb_miso_t    m_miso [CB_ARB_NUM_MASTERS];
  s_cb_mosi_t    s_mosi;

  // Read path state
  logic          rd_lock;
  cb_master_id_t rd_lock_id, rd_rr_ptr, rd_gnt, rd_head;
  logic          rd_full, rd_empty, rd_pop, rd_can, rd_req, rd_addr_hs;

  // Write path state
  wr_arb_st_t    wr_state, wr_state_nx;
  cb_master_id_t wr_id, wr_id_nx, wr_rr_ptr, wr_gnt, wr_head;
  logic          wr_aw_done, wr_aw_done_nx, wr_w_done, wr_w_done_nx;
  logic          wr_full, wr_empty, wr_pop, wr_can, wr_active;
  logic          wr_fwd_aw, wr_fwd_w, wr_aw_hs, wr_w_hs, wr_push;

  assign m_mosi[0] = m0_cb_mosi_i;
  assign m_mosi[1] = m1_cb_mosi_i;

  // ---------------- read path ----------------
  assign rd_pop     = s_cb_miso_i.rd_data_valid && !rd_empty && m_mosi[rd_head].rd_data_ready;
  assign rd_can     = !rd_full || rd_pop;
  assign rd_gnt     = rd_lock ? rd_lock_id
                    : cb_arb_pick(m_mosi[0].rd_addr_valid, m_mosi[1].rd_addr_valid,
                                  RR_EN != 0, rd_rr_ptr);
  assign rd_req     = rd_can && m_mosi[rd_gnt].rd_addr_valid;
  assign rd_addr_hs = rd_req && s_cb_miso_i.rd_addr_ready;

  // An offered-but-stalled address pins the grant so the slave sees a stable payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lock    <= 1'b0;
      rd_lock_id <= 1'b0;
      rd_rr_ptr  <= 1'b1;
    end else begin
      rd_lock    <= rd_req && !s_cb_miso_i.rd_addr_ready;
      rd_lock_id <= rd_gnt;
      if (rd_addr_hs && RR_EN != 0) rd_rr_ptr <= ~rd_gnt;
    end
  end

  cb_arb_ord_fifo #(.DEPTH(MAX_OT_TXN)) u_rd_ord_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_addr_hs),
    .push_id (rd_gnt),
    .pop     (rd_pop),
    .head    (rd_head),
    .full    (rd_full),
    .empty   (rd_empty)
  );

  // ---------------- write path ----------------
  assign wr_pop = s_cb_miso_i.wr_resp_valid && !wr_empty && m_mosi[wr_head].wr_resp_ready;
  assign wr_can = !wr_full || wr_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= WR_IDLE;
      wr_id      <= 1'b0;
      wr_aw_done <= 1'b0;
      wr_w_done  <= 1'b0;
      wr_rr_ptr  <= 1'b1;
    end else begin
      wr_state   <= wr_state_nx;
      wr_id      <= wr_id_nx;
      wr_aw_done <= wr_aw_done_nx;
      wr_w_done  <= wr_w_done_nx;
      if (wr_push && RR_EN != 0) wr_rr_ptr <= ~wr_gnt;
    end
  end

  // The done flags let an address or data handshake in IDLE carry into the locked states.
  always_comb begin
    wr_state_nx   = wr_state;
    wr_id_nx      = wr_id;
    wr_aw_done_nx = wr_aw_done;
    wr_w_done_nx  = wr_w_done;
    unique case (wr_state)
      WR_IDLE: begin
        if (wr_active && !wr_push) begin
          wr_state_nx   = WR_ADDR;
          wr_id_nx      = wr_gnt;
          wr_aw_done_nx = wr_aw_hs;
          wr_w_done_nx  = wr_w_hs;
        end
      end
      WR_ADDR: begin
        if (wr_push) begin
          wr_state_nx   = WR_IDLE;
          wr_aw_done_nx = 1'b0;
          wr_w_done_nx  = 1'b0;
        end else begin
          wr_aw_done_nx = wr_aw_done || wr_aw_hs;
          wr_w_done_nx  = wr_w_done || wr_w_hs;
          if (wr_aw_done || wr_aw_hs) wr_state_nx = WR_DATA;
        end
      end
      WR_DATA: begin
        if (wr_push) begin
          wr_state_nx   = WR_IDLE;
          wr_aw_done_nx = 1'b0;
          wr_w_done_nx  = 1'b0;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  always_comb begin
    wr_gnt    = wr_id;
    wr_active = 1'b1;
    if (wr_state == WR_IDLE) begin
      wr_gnt    = cb_arb_pick(m_mosi[0].wr_addr_valid, m_mosi[1].wr_addr_valid,
                              RR_EN != 0, wr_rr_ptr);
      wr_active = wr_can && (m_mosi[0].wr_addr_valid || m_mosi[1].wr_addr_valid);
    end
    wr_fwd_aw = wr_active && !wr_aw_done;
    wr_fwd_w  = wr_active && !wr_w_done;
    wr_aw_hs  = wr_fwd_aw && m_mosi[wr_gnt].wr_addr_valid && s_cb_miso_i.wr_addr_ready;
    wr_w_hs   = wr_fwd_w && m_mosi[wr_gnt].wr_data_valid && s_cb_miso_i.wr_data_ready;
    wr_push   = wr_active && (wr_aw_done || wr_aw_hs) && (wr_w_done || wr_w_hs);
  end

  cb_arb_ord_fifo #(.DEPTH(MAX_OT_TXN)) u_wr_ord_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_push),
    .push_id (wr_gnt),
    .pop     (wr_pop),
    .head    (wr_head),
    .full    (wr_full),
    .empty   (wr_empty)
  );

  // ---------------- bus muxing ----------------
  always_comb begin
    s_mosi = '0;
    for (int unsigned i = 0; i < CB_ARB_NUM_MASTERS; i++) begin
      m_miso[i]               = '0;
      m_miso[i].rd_data       = s_cb_miso_i.rd_data;
      m_miso[i].rd_data_error = s_cb_miso_i.rd_data_error;
      m_miso[i].wr_resp_error = s_cb_miso_i.wr_resp_error;
    end

    s_mosi.rd_addr                 = m_mosi[rd_gnt].rd_addr;
    s_mosi.rd_addr_valid           = rd_req;
    m_miso[rd_gnt].rd_addr_ready   = rd_can && s_cb_miso_i.rd_addr_ready;

    // With nothing outstanding a stray response is swallowed rather than stalling the slave.
    s_mosi.rd_data_ready = 1'b1;
    if (!rd_empty) begin
      s_mosi.rd_data_ready           = m_mosi[rd_head].rd_data_ready;
      m_miso[rd_head].rd_data_valid  = s_cb_miso_i.rd_data_valid;
    end

    s_mosi.wr_addr                 = m_mosi[wr_gnt].wr_addr;
    s_mosi.wr_data                 = m_mosi[wr_gnt].wr_data;
    s_mosi.wr_strobe               = m_mosi[wr_gnt].wr_strobe;
    s_mosi.wr_addr_valid           = wr_fwd_aw && m_mosi[wr_gnt].wr_addr_valid;
    s_mosi.wr_data_valid           = wr_fwd_w && m_mosi[wr_gnt].wr_data_valid;
    m_miso[wr_gnt].wr_addr_ready   = wr_fwd_aw && s_cb_miso_i.wr_addr_ready;
    m_miso[wr_gnt].wr_data_ready   = wr_fwd_w && s_cb_miso_i.wr_data_ready;

    s_mosi.wr_resp_ready = 1'b1;
    if (!wr_empty) begin
      s_mosi.wr_resp_ready           = m_mosi[wr_head].wr_resp_ready;
      m_miso[wr_head].wr_resp_valid  = s_cb_miso_i.wr_resp_valid;
    end
  end

  assign m0_cb_miso_o = rst ? '0 : m_miso[0];
  assign m1_cb_miso_o = rst ? '0 : m_miso[1];
  assign s_cb_mosi_o  = rst ? '0 : s_mosi;

`ifdef NOX_CB_ARB_PERF_EN
  logic [31:0] perf_cnt [CB_ARB_NUM_MASTERS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt[0] <= '0;
      perf_cnt[1] <= '0;
    end else if (rd_addr_hs) begin
      perf_cnt[rd_gnt] <= perf_cnt[rd_gnt] + 32'd1;
    end
  end

  assign perf_rd_cnt_o = {perf_cnt[1], perf_cnt[0]};
`else
  assign perf_rd_cnt_o = '0;
`endif

endmodule
